mult_div_seq: RTL

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

---
 rtl/mult_div_seq_pkg.sv | 24 ++
 rtl/mdu_addsub.sv | 19 +
 rtl/mult_div_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mult_div_seq_pkg.sv
// Shared encodings, widths and helpers for the sequential multiply/divide unit.
package mult_div_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = XLEN + 1;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Two's-complement magnitude; 0x80000000 maps to the unsigned value 2^31.
  function automatic logic [XLEN-1:0] mag_of(input logic [XLEN-1:0] x);
    mag_of = x[XLEN-1] ? -x : x;
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// 33-bit adder/subtractor shared by the shift-add and restoring-divide steps.
module mdu_addsub
  import mult_div_seq_pkg::*;
(
  input  logic [AW-1:0] x_i,
  input  logic [AW-1:0] y_i,
  input  logic          sub_i,
  output logic [AW-1:0] sum_c,
  output logic          co_c
);

  logic [AW:0] full;

  // For subtraction co_c = 1 means no borrow (x_i >= y_i).
  assign full  = {1'b0, x_i} + {1'b0, (sub_i ? ~y_i : y_i)} + {{AW{1'b0}}, sub_i};
  assign sum_c = full[AW-1:0];
  assign co_c  = full[AW];

endmodule

// File: rtl/mult_div_seq.sv
// Sequential signed 32x32 multiply / 32/32 divide with MIPS hi/lo results.
module mult_div_seq
  import mult_div_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_e             state_q;
  logic               op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [XLEN-1:0]    rem_q;
  logic [XLEN-1:0]    opnd_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [XLEN-1:0]    hi_q;
  logic [XLEN-1:0]    lo_q;

  logic [AW-1:0]      as_x;
  logic [AW-1:0]      as_y;
  logic               as_sub;
  logic [AW-1:0]      as_sum;
  logic               as_co;
  logic [2*XLEN-1:0]  acc_d;
  logic [XLEN-1:0]    rem_d;
  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN-1:0]    quo_fix;
  logic [XLEN-1:0]    rmd_fix;

  mdu_addsub u_addsub (
    .x_i   (as_x),
    .y_i   (as_y),
    .sub_i (as_sub),
    .sum_c (as_sum),
    .co_c  (as_co)
  );

  // One iteration step plus the sign-corrected results.
  always_comb begin
    as_x   = {1'b0, acc_q[2*XLEN-1:XLEN]};
    as_y   = {1'b0, opnd_q};
    as_sub = 1'b0;
    acc_d  = acc_q;
    rem_d  = rem_q;
    if (op_q == OP_MULT) begin
      acc_d = {(acc_q[0] ? as_sum : {1'b0, acc_q[2*XLEN-1:XLEN]}), acc_q[XLEN-1:1]};
    end else begin
      as_x   = {rem_q, acc_q[XLEN-1]};
      as_sub = 1'b1;
      rem_d  = as_co ? as_sum[XLEN-1:0] : as_x[XLEN-1:0];
      acc_d  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], as_co};
    end
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rmd_fix  = neg_rem_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // The done pulse is still visible here, so starts are blocked for it.
          if (start && !done_q) begin
            op_q      <= op;
            cnt_q     <= '0;
            rem_q     <= '0;
            neg_res_q <= a[XLEN-1] ^ b[XLEN-1];
            neg_rem_q <= a[XLEN-1];
            busy_q    <= 1'b1;
            if (op == OP_MULT) begin
              opnd_q  <= mag_of(a);
              acc_q   <= {{XLEN{1'b0}}, mag_of(b)};
              state_q <= ST_CALC;
            end else begin
              opnd_q  <= mag_of(b);
              acc_q   <= {{XLEN{1'b0}}, mag_of(a)};
              state_q <= (b == '0) ? ST_DONE : ST_CALC;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (op_q == OP_MULT) begin
            hi_q <= prod_fix[2*XLEN-1:XLEN];
            lo_q <= prod_fix[XLEN-1:0];
          end else begin
            hi_q <= rmd_fix;
            lo_q <= quo_fix;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          dz_q    <= (op_q == OP_DIV) && (opnd_q == '0);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
